// File: rtl/exu_redirect_ctrl_pkg.sv
// Purpose : shared core types for the EXU redirect path (rv32i PC types, FSM state, BPU update entry).
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package exu_redirect_ctrl_pkg;

    localparam int RV_PC_SIZE = 32;

    typedef logic [RV_PC_SIZE-1:0] rv32_pc_t;

    // Redirect controller state: only IDLE accepts branch-resolution packets.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_REDIR = 1'b1
    } redir_state_e;

    // One predictor-training record, pushed per resolved branch.
    typedef struct packed {
        rv32_pc_t pc;
        rv32_pc_t target;
        logic     taken;
    } bpu_upd_t;

endpackage

// File: rtl/exu_bpu_upd_fifo.sv
// Purpose : generic first-in first-out buffer for branch-predictor update entries.
// Latency : 1 cycle push-to-pop (entry visible on out_dat the cycle after the push edge).
// Backpressure: in_rdy = !full (registered occupancy); out_vld = !empty; pop frees a slot next cycle.
// Ports   : clk/rst_n; in_vld/in_dat/in_rdy write side; out_vld/out_dat/out_rdy read side.
module exu_bpu_upd_fifo #(
    parameter type T     = logic,
    parameter int  DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_vld,
    input  T     in_dat,
    output logic in_rdy,
    output logic out_vld,
    output T     out_dat,
    input  logic out_rdy
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    T            mem_q [DEPTH];

    logic push;
    logic pop;
    logic full;
    logic empty;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        in_rdy   = !full;
        out_vld  = !empty;
        out_dat  = mem_q[rd_ptr_q[AW-1:0]];
        push     = in_vld && !full;
        pop      = !empty && out_rdy;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: nothing is visible until a pointer moves past it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_dat;
        end
    end

endmodule

// File: rtl/exu_redirect_ctrl.sv
// Purpose : turns branch-resolution packets into fetch redirects, flush pulses, predictor updates and stats.
// Latency : redir_vld and flush rise 1 cycle after a mispredicted packet is accepted; update entry visible 1 cycle after accept.
// Backpressure: rsp_rdy low while a redirect is outstanding or the update FIFO is full; upd_rdy never delays a redirect.
// Ports   : rsp_* packet in; redir_vld/redir_pc/redir_rdy fetch redirect; flush, stall_issue;
//           upd_* predictor training out; br_cnt/mispred_cnt 32-bit wrapping counters.
module exu_redirect_ctrl
    import exu_redirect_ctrl_pkg::*;
#(
    parameter int PC_W      = RV_PC_SIZE,
    parameter int UPD_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rsp_vld,
    output logic            rsp_rdy,
    input  logic [PC_W-1:0] rsp_pc,
    input  logic [PC_W-1:0] rsp_target_pc,
    input  logic            rsp_taken,
    input  logic            rsp_pred_true,
    output logic            redir_vld,
    output logic [PC_W-1:0] redir_pc,
    input  logic            redir_rdy,
    output logic            flush,
    output logic            stall_issue,
    output logic            upd_vld,
    input  logic            upd_rdy,
    output logic [PC_W-1:0] upd_pc,
    output logic [PC_W-1:0] upd_target,
    output logic            upd_taken,
    output logic [31:0]     br_cnt,
    output logic [31:0]     mispred_cnt
);

    redir_state_e    state_q, state_d;
    logic [PC_W-1:0] redir_pc_q, redir_pc_d;
    logic            flush_q, flush_d;
    logic [31:0]     br_cnt_q, br_cnt_d;
    logic [31:0]     mispred_cnt_q, mispred_cnt_d;

    logic     fifo_in_rdy;
    logic     accept;
    logic     mispred;
    bpu_upd_t push_dat;
    bpu_upd_t head_dat;

    always_comb begin
        rsp_rdy = (state_q == ST_IDLE) && fifo_in_rdy;
        accept  = rsp_vld && rsp_rdy;
        mispred = accept && !rsp_pred_true;

        push_dat.pc     = RV_PC_SIZE'(rsp_pc);
        push_dat.target = RV_PC_SIZE'(rsp_target_pc);
        push_dat.taken  = rsp_taken;

        state_d       = state_q;
        redir_pc_d    = redir_pc_q;
        flush_d       = mispred;
        br_cnt_d      = br_cnt_q;
        mispred_cnt_d = mispred_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (mispred) begin
                    state_d    = ST_REDIR;
                    redir_pc_d = rsp_target_pc;
                end
            end
            ST_REDIR: begin
                if (redir_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            br_cnt_d = br_cnt_q + 32'd1;
        end
        if (mispred) begin
            mispred_cnt_d = mispred_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            redir_pc_q    <= '0;
            flush_q       <= 1'b0;
            br_cnt_q      <= '0;
            mispred_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            redir_pc_q    <= redir_pc_d;
            flush_q       <= flush_d;
            br_cnt_q      <= br_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    // Every accepted packet trains the predictor; acceptance already implies a free slot.
    exu_bpu_upd_fifo #(
        .T     (bpu_upd_t),
        .DEPTH (UPD_DEPTH)
    ) u_upd_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (accept),
        .in_dat  (push_dat),
        .in_rdy  (fifo_in_rdy),
        .out_vld (upd_vld),
        .out_dat (head_dat),
        .out_rdy (upd_rdy)
    );

    always_comb begin
        redir_vld   = (state_q == ST_REDIR);
        stall_issue = (state_q == ST_REDIR);
        redir_pc    = redir_pc_q;
        flush       = flush_q;
        upd_pc      = PC_W'(head_dat.pc);
        upd_target  = PC_W'(head_dat.target);
        upd_taken   = head_dat.taken;
        br_cnt      = br_cnt_q;
        mispred_cnt = mispred_cnt_q;
    end

endmodule

// File: tb/tb_exu_redirect_ctrl.sv
// Purpose : self-checking bench for exu_redirect_ctrl: queue-based model plus directed literal checks.
// Latency : n/a.
// Backpressure: driven directly via upd_rdy / redir_rdy stimulus.
module tb_exu_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        rsp_vld = 1'b0;
    logic        rsp_rdy;
    logic [31:0] rsp_pc = '0;
    logic [31:0] rsp_target_pc = '0;
    logic        rsp_taken = 1'b0;
    logic        rsp_pred_true = 1'b1;
    logic        redir_vld;
    logic [31:0] redir_pc;
    logic        redir_rdy = 1'b0;
    logic        flush;
    logic        stall_issue;
    logic        upd_vld;
    logic        upd_rdy = 1'b0;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic [31:0] br_cnt;
    logic [31:0] mispred_cnt;

    always #5 clk = ~clk;

    exu_redirect_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rsp_vld       (rsp_vld),
        .rsp_rdy       (rsp_rdy),
        .rsp_pc        (rsp_pc),
        .rsp_target_pc (rsp_target_pc),
        .rsp_taken     (rsp_taken),
        .rsp_pred_true (rsp_pred_true),
        .redir_vld     (redir_vld),
        .redir_pc      (redir_pc),
        .redir_rdy     (redir_rdy),
        .flush         (flush),
        .stall_issue   (stall_issue),
        .upd_vld       (upd_vld),
        .upd_rdy       (upd_rdy),
        .upd_pc        (upd_pc),
        .upd_target    (upd_target),
        .upd_taken     (upd_taken),
        .br_cnt        (br_cnt),
        .mispred_cnt   (mispred_cnt)
    );

    int n_chk  = 0;
    int n_fail = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        tk;
    } ent_t;

    localparam int DEPTH = 4;

    ent_t        m_q[$];
    ent_t        m_e;
    bit          m_pending;   // a redirect is waiting for fetch
    bit          m_flush;
    logic [31:0] m_rpc;
    logic [31:0] m_br;
    logic [31:0] m_mis;
    bit          m_rdy;
    bit          m_acc;
    bit          m_pop;

    task automatic m_reset();
        m_q.delete();
        m_pending = 0;
        m_flush   = 0;
        m_rpc     = '0;
        m_br      = '0;
        m_mis     = '0;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_reset();
            end else begin
                m_rdy = !m_pending && (m_q.size() < DEPTH);
                m_acc = rsp_vld && m_rdy;
                m_pop = (m_q.size() != 0) && upd_rdy;
                m_flush = m_acc && !rsp_pred_true;
                if (m_pending) begin
                    if (redir_rdy) m_pending = 0;
                end else if (m_acc && !rsp_pred_true) begin
                    m_pending = 1;
                    m_rpc     = rsp_target_pc;
                end
                if (m_pop) void'(m_q.pop_front());
                if (m_acc) begin
                    m_e.pc  = rsp_pc;
                    m_e.tgt = rsp_target_pc;
                    m_e.tk  = rsp_taken;
                    m_q.push_back(m_e);
                    m_br = m_br + 32'd1;
                    if (!rsp_pred_true) m_mis = m_mis + 32'd1;
                end
            end
        end
    end

    // One compare process, away from the active edge.
    bit chk_on = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                chk("m_rsp_rdy", {31'd0, rsp_rdy}, {31'd0, !m_pending && (m_q.size() < DEPTH)});
                chk("m_redir_vld", {31'd0, redir_vld}, {31'd0, m_pending});
                chk("m_stall_issue", {31'd0, stall_issue}, {31'd0, m_pending});
                chk("m_flush", {31'd0, flush}, {31'd0, m_flush});
                chk("m_redir_pc", redir_pc, m_rpc);
                chk("m_br_cnt", br_cnt, m_br);
                chk("m_mispred_cnt", mispred_cnt, m_mis);
                chk("m_upd_vld", {31'd0, upd_vld}, {31'd0, m_q.size() != 0});
                if (m_q.size() != 0) begin
                    chk("m_upd_pc", upd_pc, m_q[0].pc);
                    chk("m_upd_target", upd_target, m_q[0].tgt);
                    chk("m_upd_taken", {31'd0, upd_taken}, {31'd0, m_q[0].tk});
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [31:0] pc, input logic [31:0] tgt, input logic tk, input logic pr);
        rsp_pc        = pc;
        rsp_target_pc = tgt;
        rsp_taken     = tk;
        rsp_pred_true = pr;
        rsp_vld       = 1'b1;
        for (int i = 0; i < 20 && !rsp_rdy; i++) step();
        chk("wait_rsp_rdy", {31'd0, rsp_rdy}, 32'd1);
        step();
        rsp_vld = 1'b0;
    endtask

    int redir_cycles;

    initial begin
        #1 rst_n = 1'b0;
        chk_on = 1;
        step();
        step();
        rst_n = 1'b1;
        chk("rst_br_cnt", br_cnt, 32'd0);
        chk("rst_redir_pc", redir_pc, 32'd0);
        chk("rdy_after_reset", {31'd0, rsp_rdy}, 32'd1);

        // Correctly predicted branch: training entry only.
        send(32'h100, 32'h104, 1'b0, 1'b1);
        chk("s1_flush", {31'd0, flush}, 32'd0);
        chk("s1_upd_pc", upd_pc, 32'h100);
        chk("s1_upd_target", upd_target, 32'h104);
        chk("s1_upd_taken", {31'd0, upd_taken}, 32'd0);
        chk("s1_br_cnt", br_cnt, 32'd1);
        chk("s1_mispred_cnt", mispred_cnt, 32'd0);
        upd_rdy = 1'b1;
        step();
        upd_rdy = 1'b0;

        // Mispredict with fetch stalling the redirect for 3 cycles.
        send(32'h200, 32'h180, 1'b1, 1'b0);
        chk("s2_flush", {31'd0, flush}, 32'd1);
        chk("s2_redir_pc", redir_pc, 32'h180);
        chk("s2_mispred_cnt", mispred_cnt, 32'd1);
        rsp_pc = 32'h300; rsp_target_pc = 32'h304; rsp_taken = 1'b0; rsp_pred_true = 1'b1;
        rsp_vld = 1'b1;
        redir_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) redir_rdy = 1'b1;
            if (redir_vld) redir_cycles++;
            chk("s2_rdy_in_redir", {31'd0, rsp_rdy}, 32'd0);
            chk("s2_redir_pc_hold", redir_pc, 32'h180);
            step();
        end
        redir_rdy = 1'b0;
        chk("s2_redir_cycles", redir_cycles, 32'd4);
        chk("s2_redir_done", {31'd0, redir_vld}, 32'd0);
        chk("s2_br_held", br_cnt, 32'd2);
        step();
        rsp_vld = 1'b0;
        chk("s2_br_after", br_cnt, 32'd3);
        upd_rdy = 1'b1;
        step();
        step();
        upd_rdy = 1'b0;
        chk("s2_drained", {31'd0, upd_vld}, 32'd0);

        // Fill the update FIFO under back-pressure.
        for (int i = 0; i < 4; i++) send(32'h400 + 32'(i * 16), 32'h404 + 32'(i * 16), 1'(i % 2), 1'b1);
        chk("s3_full_rdy", {31'd0, rsp_rdy}, 32'd0);
        chk("s3_head0", upd_pc, 32'h400);
        upd_rdy = 1'b1;
        step();
        upd_rdy = 1'b0;
        chk("s3_rdy_after_pop", {31'd0, rsp_rdy}, 32'd1);
        chk("s3_head1", upd_pc, 32'h410);
        upd_rdy = 1'b1;
        for (int j = 1; j < 4; j++) begin
            chk("s3_order", upd_pc, 32'h400 + 32'(j * 16));
            step();
        end
        upd_rdy = 1'b0;
        chk("s3_empty", {31'd0, upd_vld}, 32'd0);

        // Mispredict with fetch always ready, then a back-to-back packet.
        redir_rdy = 1'b1;
        send(32'h500, 32'h600, 1'b1, 1'b0);
        chk("s4_redir_vld", {31'd0, redir_vld}, 32'd1);
        chk("s4_redir_pc", redir_pc, 32'h600);
        rsp_pc = 32'h504; rsp_target_pc = 32'h508; rsp_taken = 1'b0; rsp_pred_true = 1'b1;
        rsp_vld = 1'b1;
        step();
        chk("s4_redir_one_cycle", {31'd0, redir_vld}, 32'd0);
        chk("s4_rdy_back", {31'd0, rsp_rdy}, 32'd1);
        step();
        rsp_vld = 1'b0;
        redir_rdy = 1'b0;
        chk("s4_br_cnt", br_cnt, 32'd9);
        chk("s4_mispred_cnt", mispred_cnt, 32'd2);
        upd_rdy = 1'b1;
        step();
        step();
        upd_rdy = 1'b0;

        // Reset while a redirect is outstanding.
        send(32'h700, 32'h740, 1'b0, 1'b0);
        chk("s5_in_redir", {31'd0, redir_vld}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("s5_redir_vld", {31'd0, redir_vld}, 32'd0);
        chk("s5_flush", {31'd0, flush}, 32'd0);
        chk("s5_stall", {31'd0, stall_issue}, 32'd0);
        chk("s5_br_cnt", br_cnt, 32'd0);
        chk("s5_mispred_cnt", mispred_cnt, 32'd0);
        chk("s5_upd_vld", {31'd0, upd_vld}, 32'd0);
        chk("s5_redir_pc", redir_pc, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("s5_no_redir", {31'd0, redir_vld}, 32'd0);
            chk("s5_no_flush", {31'd0, flush}, 32'd0);
            step();
        end

        // Branch counter wrap.
        force dut.br_cnt_q = 32'hFFFF_FFFF;
        m_br = 32'hFFFF_FFFF;
        #1 release dut.br_cnt_q;
        chk("s6_preload", br_cnt, 32'hFFFF_FFFF);
        send(32'h800, 32'h804, 1'b1, 1'b1);
        chk("s6_wrap", br_cnt, 32'd0);
        step();

        chk_on = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/exu_redirect_ctrl.md
EXU_REDIRECT_CTRL -- requirements
Module: exu_redirect_ctrl

Interface
REQ-001 Parameter PC_W, default `RV_PC_SIZE (32), width of all PC fields.
REQ-002 Parameter UPD_DEPTH, default 4, BPU update FIFO entries; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 rsp_vld  input  1  branch-resolution packet valid (from the branch handler's ex_rsp).
REQ-006 rsp_rdy  output  1  packet accepted when rsp_vld && rsp_rdy.
REQ-007 rsp_pc, rsp_target_pc  input  PC_W each  resolved branch PC and next PC.
REQ-008 rsp_taken, rsp_pred_true  input  1 each  actual direction; prediction was correct.
REQ-009 redir_vld  output  1  fetch-redirect request; redir_pc  output  PC_W.
REQ-010 redir_rdy  input  1  fetch accepts the redirect.
REQ-011 flush  output  1  one-cycle pulse killing younger in-flight instructions.
REQ-012 stall_issue  output  1  blocks EXU issue while a redirect is outstanding.
REQ-013 upd_vld  output  1; upd_rdy  input  1; upd_pc, upd_target  output  PC_W; upd_taken  output  1: predictor training port.
REQ-014 br_cnt, mispred_cnt  output  32 each  retired-branch and mispredict counters.

Function
REQ-015 FSM states: IDLE, REDIR; only IDLE accepts packets.
REQ-016 rsp_rdy = (state==IDLE) && !fifo_full, combinational; independent of rsp_vld.
REQ-017 Every accepted packet pushes {rsp_pc, rsp_target_pc, rsp_taken} into the update FIFO in the same edge.
REQ-018 Accept with rsp_pred_true=1: state stays IDLE, no flush, no redirect.
REQ-019 Accept with rsp_pred_true=0: redir_pc registered from rsp_target_pc, state goes to REDIR, flush=1 for exactly the following cycle.
REQ-020 REDIR: redir_vld=1, stall_issue=1, rsp_rdy=0; redir_pc stable until handshake.
REQ-021 REDIR with redir_rdy=1: return to IDLE next edge; redir_vld deasserts; earliest new acceptance is that next cycle.
REQ-022 Redirect latency: redir_vld rises one cycle after the mispredicted packet's accept edge; redir_rdy may be high combinationally in that cycle.
REQ-023 upd_vld = !fifo_empty; head entry drives upd_*; pop on upd_vld && upd_rdy; FIFO is first-in first-out.
REQ-024 Push and pop in the same cycle: occupancy unchanged; push when full is impossible by REQ-016; pop-while-full frees a slot only for the next cycle.
REQ-025 br_cnt increments by 1 per accepted packet; mispred_cnt by 1 per accepted packet with rsp_pred_true=0; both wrap modulo 2^32.
REQ-026 Update-port back-pressure (upd_rdy=0) never delays a redirect already pending.

Reset
REQ-027 rst_n low asynchronously forces: state=IDLE, FIFO empty, redir_vld=0, flush=0, stall_issue=0, upd_vld=0, br_cnt=0, mispred_cnt=0, redir_pc=0.
REQ-028 Reset mid-REDIR abandons the redirect; no flush or redir_vld after release until a new mispredict.
REQ-029 rsp_rdy may rise in the first cycle after rst_n deasserts.

Structure
REQ-030 FSM state enum and the update-entry packed struct {pc, target, taken} live in the shared core package alongside the rv32i types.
REQ-031 The update FIFO is a separate sub-module exu_bpu_upd_fifo (parameterised by depth and entry type); FSM, counters and redirect register stay in exu_redirect_ctrl.

Verification
REQ-032 Reset, then packet pc=0x100, target=0x104, taken=0, pred_true=1 -> no flush, upd entry {0x100,0x104,0}, br_cnt=1, mispred_cnt=0.
REQ-033 Packet pc=0x200, target=0x180, pred_true=0, redir_rdy low 3 cycles -> flush one cycle, redir_vld/stall_issue 3+1 cycles, redir_pc=0x180, rsp_rdy=0 throughout, mispred_cnt=1.
REQ-034 upd_rdy=0, push 4 correct packets -> rsp_rdy=0 after 4th; raise upd_rdy one cycle -> one pop, rsp_rdy=1 next cycle, order preserved.
REQ-035 Mispredict with redir_rdy held 1 -> redir_vld exactly one cycle, back-to-back packet accepted on the following cycle.
REQ-036 rst_n asserted during REDIR -> redir_vld, flush, stall_issue low immediately; counters 0; no redirect after release.
REQ-037 Preload br_cnt path with 2^32-1 accepts (or force) -> next accept wraps br_cnt to 0.
